// File: rtl/key_conditioner.sv
// key_conditioner: per-key push-button front end.
// Each lane synchronises its raw pin and normalises the polarity so that
// 1 means pressed. It debounces the level and then runs a small hold state
// machine. That machine produces press/release pulses and an auto-repeat
// stream for held keys.
module key_conditioner #(
  parameter int NUM_KEYS             = 3,
  parameter bit ACTIVE_LOW           = 1'b1,
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic                clk_50mhz_i,
  input  logic                nreset_i,
  input  logic [NUM_KEYS-1:0] key_raw_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic [NUM_KEYS-1:0] key_repeat_o
);

  localparam int HOLD_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  // Terminal counts: each counter clears on reaching these, so it never wraps.
  localparam logic [DB_W-1:0]   DB_TC     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_TC  = HOLD_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [HOLD_W-1:0] PERIOD_TC = HOLD_W'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_HELD_DELAY  = 2'd1,
    ST_HELD_REPEAT = 2'd2
  } lane_state_e;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_lane
      logic              raw_norm;
      logic              sync1_q, sync2_q;
      logic              stable_q, stable_d;
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic              differ, accept, rise, fall;
      lane_state_e       state_q, state_d;
      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              repeat_q, repeat_d;

      assign raw_norm = ACTIVE_LOW ? ~key_raw_i[gi] : key_raw_i[gi];

      // Two-flop synchroniser. Reset holds the normalised released value.
      always_ff @(posedge clk_50mhz_i or negedge nreset_i) begin
        if (!nreset_i) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
        end else begin
          sync1_q <= raw_norm;
          sync2_q <= sync1_q;
        end
      end

      // Debounce: count while the sample disagrees with the stable level.
      // At terminal count, accept the new level.
      always_comb begin
        differ   = (sync2_q != stable_q);
        accept   = differ && (db_cnt_q == DB_TC);
        rise     = accept && !stable_q;
        fall     = accept && stable_q;
        db_cnt_d = (!differ || accept) ? '0 : db_cnt_q + DB_W'(1);
        stable_d = accept ? ~stable_q : stable_q;
      end

      // Debounce counter and stable (accepted) level register.
      always_ff @(posedge clk_50mhz_i or negedge nreset_i) begin
        if (!nreset_i) begin
          db_cnt_q <= '0;
          stable_q <= 1'b0;
        end else begin
          db_cnt_q <= db_cnt_d;
          stable_q <= stable_d;
        end
      end

      // Hold state machine. A release takes priority over a repeat that is
      // due on the same cycle.
      always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
          ST_RELEASED: begin
            hold_d = '0;
            if (rise) begin
              state_d  = ST_HELD_DELAY;
              press_d  = 1'b1;
              repeat_d = 1'b1;
            end
          end
          ST_HELD_DELAY: begin
            if (fall) begin
              state_d   = ST_RELEASED;
              release_d = 1'b1;
              hold_d    = '0;
            end else if (hold_q == DELAY_TC) begin
              state_d  = ST_HELD_REPEAT;
              repeat_d = 1'b1;
              hold_d   = '0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
          ST_HELD_REPEAT: begin
            if (fall) begin
              state_d   = ST_RELEASED;
              release_d = 1'b1;
              hold_d    = '0;
            end else if (hold_q == PERIOD_TC) begin
              repeat_d = 1'b1;
              hold_d   = '0;
            end else begin
              hold_d = hold_q + HOLD_W'(1);
            end
          end
          default: begin
            state_d = ST_RELEASED;
            hold_d  = '0;
          end
        endcase
      end

      // State, hold counter and registered pulse outputs.
      always_ff @(posedge clk_50mhz_i or negedge nreset_i) begin
        if (!nreset_i) begin
          state_q   <= ST_RELEASED;
          hold_q    <= '0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          repeat_q  <= 1'b0;
        end else begin
          state_q   <= state_d;
          hold_q    <= hold_d;
          press_q   <= press_d;
          release_q <= release_d;
          repeat_q  <= repeat_d;
        end
      end

      assign key_level_o[gi]   = stable_q;
      assign key_press_o[gi]   = press_q;
      assign key_release_o[gi] = release_q;
      assign key_repeat_o[gi]  = repeat_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE=4, DELAY=10, PERIOD=3.
// Cycle n counts the posedges after a stimulus change. The first such edge
// is the sampling edge E, so an accepted change shows up after step n = 6.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       nreset;
  logic [2:0] key_raw;
  logic [2:0] level, press, release_p, repeat_p;
  logic [11:0] obs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign obs = {level, press, release_p, repeat_p};

  key_conditioner #(
    .NUM_KEYS(3), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_PERIOD_CYCLES(3)
  ) dut (
    .clk_50mhz_i  (clk),
    .nreset_i     (nreset),
    .key_raw_i    (key_raw),
    .key_level_o  (level),
    .key_press_o  (press),
    .key_release_o(release_p),
    .key_repeat_o (repeat_p)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with all keys pressed, then power-up press and release of all keys.
  task automatic test_reset();
    logic [11:0] e;
    nreset  = 1'b0;
    key_raw = 3'b000;
    for (int n = 1; n <= 3; n++) begin
      step();
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold n=%0d got=%h exp=%h", n, obs, 12'h000);
      end
    end
    nreset = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      step();
      e = {((n >= 6 && n < 12) ? 3'b111 : 3'b000), ((n == 6) ? 3'b111 : 3'b000),
           ((n == 12) ? 3'b111 : 3'b000), ((n == 6) ? 3'b111 : 3'b000)};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_press n=%0d got=%h exp=%h", n, obs, e);
      end
      if (n == 6) key_raw = 3'b111;
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  // Key0 held 30 cycles: press at 6, repeats 6,16,19,...,34, release at 36.
  task automatic test_clean_press();
    logic [11:0] e;
    logic        rp;
    key_raw = 3'b110;
    for (int n = 1; n <= 45; n++) begin
      step();
      rp = (n == 6) || (n >= 16 && n <= 34 && ((n - 16) % 3) == 0);
      e = {2'b00, (n >= 6 && n < 36), 2'b00, (n == 6), 2'b00, (n == 36), 2'b00, rp};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clean_press n=%0d got=%h exp=%h", n, obs, e);
      end
      if (n == 30) key_raw = 3'b111;
    end
    $display("test_clean_press done: errors=%0d", errors);
  endtask

  // Key1: low 3, high 1, then steady low -> press 5 edges after edge 5.
  task automatic test_bounce();
    logic [11:0] e;
    key_raw = 3'b101;
    for (int n = 1; n <= 20; n++) begin
      step();
      e = {1'b0, (n >= 10 && n < 16), 2'b00, (n == 10), 2'b00, (n == 16), 2'b00,
           (n == 10), 1'b0};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL bounce n=%0d got=%h exp=%h", n, obs, e);
      end
      if (n == 3)  key_raw = 3'b111;
      if (n == 4)  key_raw = 3'b101;
      if (n == 10) key_raw = 3'b111;
    end
    $display("test_bounce done: errors=%0d", errors);
  endtask

  // Key2: a 3-cycle low glitch must leave every output at 0.
  task automatic test_glitch();
    key_raw = 3'b011;
    for (int n = 1; n <= 15; n++) begin
      step();
      checks++;
      if (obs !== 12'h000) begin
        errors++;
        $display("FAIL glitch n=%0d got=%h exp=%h", n, obs, 12'h000);
      end
      if (n == 3) key_raw = 3'b111;
    end
    $display("test_glitch done: errors=%0d", errors);
  endtask

  // Key0 release accepted at P+13 = 19, where a repeat was due: release wins.
  task automatic test_collision();
    logic [11:0] e;
    key_raw = 3'b110;
    for (int n = 1; n <= 25; n++) begin
      step();
      e = {2'b00, (n >= 6 && n < 19), 2'b00, (n == 6), 2'b00, (n == 19), 2'b00,
           (n == 6 || n == 16)};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL collision n=%0d got=%h exp=%h", n, obs, e);
      end
      if (n == 13) key_raw = 3'b111;
    end
    $display("test_collision done: errors=%0d", errors);
  endtask

  // Keys 0/1 reach the repeat phase, then key2 is pressed. A one-cycle reset
  // follows, and all keys, still held, then re-press.
  task automatic test_mid_reset();
    logic [11:0] e;
    logic        r01, h01, h2;
    key_raw = 3'b100;
    for (int n = 1; n <= 24; n++) begin
      step();
      h01 = (n >= 6);
      h2  = (n >= 20);
      r01 = (n == 6 || n == 16 || n == 19 || n == 22);
      e = {h2, h01, h01, (n == 20), (n == 6), (n == 6), 3'b000, (n == 20), r01, r01};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_lanes n=%0d got=%h exp=%h", n, obs, e);
      end
      if (n == 14) key_raw = 3'b000;
    end
    nreset = 1'b0;
    #2;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_async got=%h exp=%h", obs, 12'h000);
    end
    step();
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_held got=%h exp=%h", obs, 12'h000);
    end
    nreset = 1'b1;
    for (int m = 1; m <= 16; m++) begin
      step();
      e = {((m >= 6 && m < 14) ? 3'b111 : 3'b000), ((m == 6) ? 3'b111 : 3'b000),
           ((m == 14) ? 3'b111 : 3'b000), ((m == 6) ? 3'b111 : 3'b000)};
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL mid_repress m=%0d got=%h exp=%h", m, obs, e);
      end
      if (m == 8) key_raw = 3'b111;
    end
    $display("test_mid_reset done: errors=%0d", errors);
  endtask

  initial begin
    nreset  = 1'b0;
    key_raw = 3'b111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_collision();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
